int_controller: RTL
===================

# int_controller

Interrupt sequencing block that drives the `INT_detected` / `INT_restore` pair consumed by the pipeline stage registers, which use them to bank and restore their contents. It latches rising edges on external interrupt lines into pending bits and arbitrates them by fixed priority. It emits a one-cycle detect pulse together with the saved PC, cause and vector. It then holds off further interrupts until a return (`mret`) is signalled and emits a one-cycle restore pulse.

## Interface
- `NUM_IRQ`, 4: number of interrupt lines (1..16).
- `VEC_BASE`, 32'h0000_0100: base address of the vector table.
- `VEC_SHIFT`, 4: log2 of the vector entry spacing in bytes.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `irq`  in  NUM_IRQ  interrupt request lines, synchronous to clk.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  NUM_IRQ  new mask value (1 = line enabled).
- `int_en`  in  1  global interrupt enable.
- `stall`  in  1  pipeline stalled; a new interrupt is not taken while high.
- `cur_pc`  in  32  PC of the MEM-stage instruction (becomes EPC).
- `mret`  in  1  one-cycle pulse: return-from-interrupt instruction retired.
- `INT_detected`  out  1  one-cycle pulse: take interrupt, bank stage registers.
- `INT_restore`  out  1  one-cycle pulse: restore banked stage registers.
- `int_vector_pc`  out  32  handler address `VEC_BASE + (cause << VEC_SHIFT)`.
- `epc`  out  32  saved `cur_pc`.
- `int_cause`  out  4  index of the line taken.
- `in_isr`  out  1  high in SERVICE and RESTORE.

## Operation
- **Edge detect:** `irq_q` registers `irq`; `rise = irq & ~irq_q`.
- **Pending set:** `pending[i]` is set at the clock edge when `rise[i] & mask[i]`.
- **Pending clear:** `pending[i]` is cleared when line `i` is taken.
- **Set and take in the same cycle:** set wins, so the bit stays pending.
- **Mask writes:** `mask` updates on `mask_we`. Masking a bit that is already pending does not clear it, but the bit is not eligible to be taken while masked.
- **Eligibility:** `eligible = pending & mask`. The lowest index has the highest priority.

State machine (in the shared package):
- **IDLE:** if `int_en & |eligible & !stall`, go to DETECT. On that same edge, capture:
  - `epc <= cur_pc`
  - `int_cause <= winning index`
  - `int_vector_pc <= VEC_BASE + (index << VEC_SHIFT)` (32-bit, wrap mod 2^32)
  - clear the winning pending bit.
- **DETECT:** `INT_detected = 1`. Go to SERVICE unconditionally.
- **SERVICE:** wait for `mret`, then go to RESTORE. No nesting: new edges only accumulate in `pending`.
- **RESTORE:** `INT_restore = 1`. Go to IDLE unconditionally.

Other rules:
- `mret` in IDLE, DETECT or RESTORE is ignored.
- `int_en` and `stall` are sampled only in IDLE.
- `INT_detected` and `INT_restore` are decoded from the state register only (glitch-free) and are never high together.
- `epc`, `int_cause` and `int_vector_pc` hold their values until the next take.

## Timing
- **Reset:** `reset_n` low clears immediately, in any state including mid-SERVICE: state to IDLE, and `pending`, `mask`, `irq_q`, `epc`, `int_cause`, `int_vector_pc` and all pulses to 0.
- **Take latency:** `irq` rises before edge E0 → pending set at E0 → DETECT entered at E1 → `INT_detected` high from E1 to E2 → SERVICE from E2.
- **Restore latency:** `mret` high before edge Em → RESTORE from Em → `INT_restore` high Em..Em+1 → IDLE from Em+1.
- **Next take after restore:** the earliest next DETECT is at edge Em+2.
- **Stall release:** with `stall` high, the block stays in IDLE. A take occurs at the first edge where `stall` was sampled low.
- **Level inputs:** a line held high produces only one pending event per rising edge.

## Structure
- **Package `int_pkg`:**
  - state enum `{IDLE, DETECT, SERVICE, RESTORE}`
  - `CAUSE_W = 4`
  - default `VEC_BASE` and `VEC_SHIFT`.
- **Sub-module `irq_pending`:** owns `irq_q`, the edge detect, `pending`, `mask` and the fixed-priority encoder. Its outputs are `any_eligible` and `win_idx`; its input is `take`.
- **Top level:** the FSM and the EPC/cause/vector registers.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-run → all outputs 0 at once; after release, a held-high `irq` produces no take until a new rising edge (mask = 0).
- **Single take:** `mask` = 4'b0010, `int_en` = 1, `cur_pc` = 0x40, `irq[1]` rises before E0 → `INT_detected` high exactly during E1–E2, `epc` = 0x40, `int_cause` = 1, `int_vector_pc` = 0x110, `in_isr` = 1.
- **Priority:** `mask` = 4'hF, `irq[2]` and `irq[0]` rise together:
  - first take has `int_cause` = 0, vector 0x100;
  - `mret` → `INT_restore` for one cycle;
  - second take has `int_cause` = 2, vector 0x120, two edges after RESTORE.
- **No nesting:** `irq[3]` rises during SERVICE → no `INT_detected` until after `INT_restore`, then cause = 3 is taken.
- **Stall and stray `mret`:** `stall` = 1 with an eligible bit pending for 5 cycles → no take; drop `stall` → DETECT on the next edge. An `mret` pulse in IDLE → no `INT_restore`.
- **Masking and enable:** `int_en` = 0, or the pending bit masked → no take, bit stays pending; re-enable → take within one cycle.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller: FSM states,
// cause width and default vector-table placement.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DETECT  = 2'd1,
    SERVICE = 2'd2,
    RESTORE = 2'd3
  } int_state_t;

  localparam int          CAUSE_W         = 4;
  localparam logic [31:0] DEF_VEC_BASE    = 32'h0000_0100;
  localparam int          DEF_VEC_SHIFT   = 4;

endpackage

// File: rtl/int_controller_if.sv
// Signal bundle between the pipeline/CSR side and the interrupt controller.
// master drives requests and control; slave is the controller itself.
interface int_controller_if
  import int_pkg::*;
#(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               int_en;
  logic               stall;
  logic [31:0]        cur_pc;
  logic               mret;
  logic               INT_detected;
  logic               INT_restore;
  logic [31:0]        int_vector_pc;
  logic [31:0]        epc;
  logic [CAUSE_W-1:0] int_cause;
  logic               in_isr;

  modport master (
    output irq, mask_we, mask_wdata, int_en, stall, cur_pc, mret,
    input  INT_detected, INT_restore, int_vector_pc, epc, int_cause, in_isr
  );

  modport slave (
    input  irq, mask_we, mask_wdata, int_en, stall, cur_pc, mret,
    output INT_detected, INT_restore, int_vector_pc, epc, int_cause, in_isr
  );
endinterface

// File: rtl/irq_pending.sv
// Edge detection, pending/mask registers and fixed-priority selection
// (lowest index wins) for the interrupt lines.
module irq_pending
  import int_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               take,
  output logic               any_eligible,
  output logic [CAUSE_W-1:0] win_idx
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;

  assign rise     = irq & ~irq_q;
  assign eligible = pending & mask;
  assign clr      = take ? (NUM_IRQ'(1) << win_idx) : '0;

  always_comb begin
    any_eligible = 1'b0;
    win_idx      = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any_eligible = 1'b1;
        win_idx      = CAUSE_W'(i);
      end
    end
  end

  // A new rising edge on the line being taken re-arms it: set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr) | (rise & mask);
      if (mask_we)
        mask <= mask_wdata;
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt sequencer: takes one interrupt at a time, pulses INT_detected
// with EPC/cause/vector, then pulses INT_restore once mret retires.
module int_controller
  import int_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] VEC_BASE  = DEF_VEC_BASE,
  parameter int          VEC_SHIFT = DEF_VEC_SHIFT
) (
  input logic             clk,
  input logic             reset_n,
  int_controller_if.slave bus
);

  int_state_t         state;
  int_state_t         state_nxt;
  logic               take;
  logic               any_eligible;
  logic [CAUSE_W-1:0] win_idx;
  logic [31:0]        epc;
  logic [31:0]        vec_pc;
  logic [CAUSE_W-1:0] cause;

  irq_pending #(.NUM_IRQ(NUM_IRQ)) u_pending (
    .clk          (clk),
    .reset_n      (reset_n),
    .irq          (bus.irq),
    .mask_we      (bus.mask_we),
    .mask_wdata   (bus.mask_wdata),
    .take         (take),
    .any_eligible (any_eligible),
    .win_idx      (win_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.int_en && any_eligible && !bus.stall) begin
          take      = 1'b1;
          state_nxt = DETECT;
        end
      end
      DETECT:  state_nxt = SERVICE;
      SERVICE: if (bus.mret) state_nxt = RESTORE;
      RESTORE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trap context is captured on the take edge and held until the next take.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc    <= '0;
      cause  <= '0;
      vec_pc <= '0;
    end else if (take) begin
      epc    <= bus.cur_pc;
      cause  <= win_idx;
      vec_pc <= VEC_BASE + (32'(win_idx) << VEC_SHIFT);
    end
  end

  assign bus.INT_detected  = (state == DETECT);
  assign bus.INT_restore   = (state == RESTORE);
  assign bus.in_isr        = (state == SERVICE) || (state == RESTORE);
  assign bus.epc           = epc;
  assign bus.int_cause     = cause;
  assign bus.int_vector_pc = vec_pc;

endmodule
